// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
// The slave modport is the cache; the master modport is the surrounding fetch stage and controller.
interface icache_if;
  logic        fetch_req_in;
  logic [31:0] pc_in;
  logic        flush_in;
  logic        ready_out;
  logic        inst_valid_out;
  logic [31:0] inst_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_data_out;
  logic        mem_r_nw_out;
  logic [2:0]  mem_type_out;
  logic        mem_activate_out;
  logic [31:0] mem_data_in;
  logic        mem_avail_in;
  logic [1:0]  mem_src_in;
  logic        mem_block_in;

  modport slave (
    input  fetch_req_in, pc_in, flush_in,
    input  mem_data_in, mem_avail_in, mem_src_in, mem_block_in,
    output ready_out, inst_valid_out, inst_out,
    output mem_addr_out, mem_data_out, mem_r_nw_out, mem_type_out, mem_activate_out
  );

  modport master (
    output fetch_req_in, pc_in, flush_in,
    output mem_data_in, mem_avail_in, mem_src_in, mem_block_in,
    input  ready_out, inst_valid_out, inst_out,
    input  mem_addr_out, mem_data_out, mem_r_nw_out, mem_type_out, mem_activate_out
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Misses read a single word through the controller's icache port and fill the line.
module icache #(
  parameter int INDEX_BITS = 4
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  icache_if.slave  bus
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, FETCH, KILL} state_t;

  state_t                state_q, state_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [31:0]           data_q [LINES];
  logic                  inst_valid_q, inst_valid_d;
  logic [31:0]           inst_q, inst_d;
  logic                  act_q, act_d;
  logic [31:0]           addr_q, addr_d;

  logic                  fill_en;
  logic [INDEX_BITS-1:0] req_idx, fill_idx;
  logic [TAG_BITS-1:0]   req_tag, fill_tag;
  logic                  hit, done;
  logic                  unused_sigs;

  assign req_idx  = bus.pc_in[INDEX_BITS+1:2];
  assign req_tag  = bus.pc_in[31:INDEX_BITS+2];
  assign fill_idx = addr_q[INDEX_BITS+1:2];
  assign fill_tag = addr_q[31:INDEX_BITS+2];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  // Only a response tagged for the icache completes; LSB responses pass by.
  assign done     = bus.mem_avail_in && (bus.mem_src_in == 2'b10);

  assign unused_sigs = ^{bus.mem_block_in, bus.pc_in[1:0]};

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    inst_valid_d = 1'b0;
    inst_d       = inst_q;
    act_d        = act_q;
    addr_d       = addr_q;
    fill_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.fetch_req_in && !bus.flush_in) begin
          if (hit) begin
            inst_valid_d = 1'b1;
            inst_d       = data_q[req_idx];
          end else begin
            addr_d  = {bus.pc_in[31:2], 2'b00};
            act_d   = 1'b1;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (done) begin
          fill_en = 1'b1;
          act_d   = 1'b0;
          state_d = IDLE;
          if (!bus.flush_in) begin
            inst_valid_d = 1'b1;
            inst_d       = bus.mem_data_in;
          end
        end else if (bus.flush_in) begin
          state_d = KILL;
        end
      end
      KILL: begin
        // The read may already be latched by the controller, so wait it out.
        if (done) begin
          fill_en = 1'b1;
          act_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fill_en) begin
      valid_d[fill_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      act_q        <= 1'b0;
      addr_q       <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      act_q        <= act_d;
      addr_q       <= addr_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.mem_data_in;
    end
  end

  assign bus.ready_out        = (state_q == IDLE);
  assign bus.inst_valid_out   = inst_valid_q;
  assign bus.inst_out         = inst_q;
  assign bus.mem_addr_out     = addr_q;
  assign bus.mem_data_out     = 32'h0;
  assign bus.mem_r_nw_out     = 1'b1;
  assign bus.mem_type_out     = 3'b000;
  assign bus.mem_activate_out = act_q;
endmodule

// File: tb/tb_icache.sv
// Directed plus randomized checks of icache against a line-level cache model and a memory function.
module tb_icache;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;

  icache_if bus ();

  icache #(.INDEX_BITS(4)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_data  [16];
  logic [31:0] last_inst;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0000_0010) return 32'h0051_0113;
    return (addr * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    last_inst = 32'h0;
  endtask

  // One fetch from IDLE; a miss is served as a controller word read after lsb foreign responses.
  task automatic do_fetch(input logic [31:0] pc, input int lsb, input int flush_k,
                          input int gap, input bit flush_done);
    int          idx;
    logic [25:0] tg;
    bit          hitx;
    bit          flushed;
    logic [31:0] aligned;
    logic [31:0] word;
    idx     = int'(pc[5:2]);
    tg      = pc[31:6];
    hitx    = m_valid[idx] && (m_tag[idx] == tg);
    aligned = {pc[31:2], 2'b00};
    word    = mem_word(aligned);
    flushed = 1'b0;
    chk("ready_pre", {31'b0, bus.ready_out}, 32'd1);
    bus.fetch_req_in = 1'b1;
    bus.pc_in        = pc;
    tick();
    bus.fetch_req_in = 1'b0;
    bus.pc_in        = $urandom;
    if (hitx) begin
      chk("hit_valid", {31'b0, bus.inst_valid_out}, 32'd1);
      chk("hit_data", bus.inst_out, m_data[idx]);
      chk("hit_noact", {31'b0, bus.mem_activate_out}, 32'd0);
      last_inst = m_data[idx];
    end else begin
      chk("miss_act", {31'b0, bus.mem_activate_out}, 32'd1);
      chk("miss_addr", bus.mem_addr_out, aligned);
      chk("miss_novalid", {31'b0, bus.inst_valid_out}, 32'd0);
      for (int k = 0; k < 4 + lsb; k++) begin
        if (gap > 0 && k == 2) begin
          rdy_in = 1'b0;
          repeat (gap) begin
            tick();
            chk("frz_act", {31'b0, bus.mem_activate_out}, 32'd1);
            chk("frz_addr", bus.mem_addr_out, aligned);
            chk("frz_ready", {31'b0, bus.ready_out}, 32'd0);
          end
          rdy_in = 1'b1;
        end
        if (k < lsb) begin
          bus.mem_avail_in = 1'b1;
          bus.mem_src_in   = 2'b01;
          bus.mem_data_in  = $urandom;
          bus.mem_block_in = 1'b1;
        end
        if (k == flush_k) begin
          bus.flush_in = 1'b1;
          flushed      = 1'b1;
        end
        tick();
        bus.mem_avail_in = 1'b0;
        bus.mem_src_in   = 2'b00;
        bus.mem_block_in = 1'b0;
        bus.flush_in     = 1'b0;
        chk("wait_act", {31'b0, bus.mem_activate_out}, 32'd1);
        chk("wait_addr", bus.mem_addr_out, aligned);
        chk("wait_novalid", {31'b0, bus.inst_valid_out}, 32'd0);
      end
      bus.mem_avail_in = 1'b1;
      bus.mem_src_in   = 2'b10;
      bus.mem_data_in  = word;
      bus.flush_in     = flush_done;
      if (flush_done) flushed = 1'b1;
      tick();
      bus.mem_avail_in = 1'b0;
      bus.mem_src_in   = 2'b00;
      bus.mem_data_in  = $urandom;
      bus.flush_in     = 1'b0;
      chk("done_valid", {31'b0, bus.inst_valid_out}, {31'b0, !flushed});
      chk("done_data", bus.inst_out, flushed ? last_inst : word);
      chk("done_noact", {31'b0, bus.mem_activate_out}, 32'd0);
      chk("done_ready", {31'b0, bus.ready_out}, 32'd1);
      if (!flushed) last_inst = word;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_data[idx]  = word;
    end
    tick();
    chk("pulse_end", {31'b0, bus.inst_valid_out}, 32'd0);
  endtask

  task automatic hit_burst(input logic [31:0] pa, input logic [31:0] pb, input logic [31:0] pc);
    logic [31:0] pcs [3];
    pcs[0] = pa;
    pcs[1] = pb;
    pcs[2] = pc;
    bus.fetch_req_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.pc_in = pcs[i];
      tick();
      chk("burst_valid", {31'b0, bus.inst_valid_out}, 32'd1);
      chk("burst_data", bus.inst_out, m_data[int'(pcs[i][5:2])]);
      last_inst = m_data[int'(pcs[i][5:2])];
    end
    bus.fetch_req_in = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] rpc;
    int          rflush;
    int          rgap;
    bus.fetch_req_in = 1'b0;
    bus.pc_in        = 32'h0;
    bus.flush_in     = 1'b0;
    bus.mem_data_in  = 32'h0;
    bus.mem_avail_in = 1'b0;
    bus.mem_src_in   = 2'b00;
    bus.mem_block_in = 1'b0;
    clear_model();

    #3 rst_in = 1'b0;
    #1;
    chk("rst_act", {31'b0, bus.mem_activate_out}, 32'd0);
    chk("rst_valid", {31'b0, bus.inst_valid_out}, 32'd0);
    chk("rst_inst", bus.inst_out, 32'd0);
    chk("rst_addr", bus.mem_addr_out, 32'd0);
    chk("rst_ready", {31'b0, bus.ready_out}, 32'd1);
    chk("const_data", bus.mem_data_out, 32'd0);
    chk("const_rnw", {31'b0, bus.mem_r_nw_out}, 32'd1);
    chk("const_type", {29'b0, bus.mem_type_out}, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    tick();

    do_fetch(32'h10, 0, -1, 0, 1'b0);
    do_fetch(32'h10, 0, -1, 0, 1'b0);
    do_fetch(32'h50, 0, -1, 0, 1'b0);
    do_fetch(32'h10, 0, -1, 0, 1'b0);
    do_fetch(32'h14, 0, -1, 0, 1'b0);
    do_fetch(32'h18, 0, -1, 0, 1'b0);
    hit_burst(32'h10, 32'h14, 32'h18);

    do_fetch(32'h24, 8, -1, 0, 1'b0);
    do_fetch(32'h28, 0, 1, 0, 1'b0);
    do_fetch(32'h28, 0, -1, 0, 1'b0);
    do_fetch(32'h2C, 0, -1, 0, 1'b1);
    do_fetch(32'h2C, 0, -1, 0, 1'b0);
    do_fetch(32'h30, 0, -1, 3, 1'b0);

    bus.fetch_req_in = 1'b1;
    bus.flush_in     = 1'b1;
    bus.pc_in        = 32'h300;
    tick();
    bus.fetch_req_in = 1'b0;
    bus.flush_in     = 1'b0;
    chk("idle_flush_act", {31'b0, bus.mem_activate_out}, 32'd0);
    chk("idle_flush_valid", {31'b0, bus.inst_valid_out}, 32'd0);
    chk("idle_flush_ready", {31'b0, bus.ready_out}, 32'd1);

    for (int n = 0; n < 40; n++) begin
      rpc    = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3));
      rflush = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      rgap   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_fetch(rpc, int'($urandom_range(0, 3)), rflush, rgap, $urandom_range(0, 7) == 0);
    end

    do_fetch(32'h10, 0, -1, 0, 1'b0);
    bus.fetch_req_in = 1'b1;
    bus.pc_in        = 32'h200;
    tick();
    bus.fetch_req_in = 1'b0;
    chk("pre_rst_act", {31'b0, bus.mem_activate_out}, 32'd1);
    #2 rst_in = 1'b0;
    #1;
    chk("arst_act", {31'b0, bus.mem_activate_out}, 32'd0);
    chk("arst_addr", bus.mem_addr_out, 32'd0);
    chk("arst_inst", bus.inst_out, 32'd0);
    chk("arst_ready", {31'b0, bus.ready_out}, 32'd1);
    @(negedge clk_in);
    rst_in = 1'b1;
    clear_model();
    do_fetch(32'h10, 0, -1, 0, 1'b0);
    do_fetch(32'h10, 0, -1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
